mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-port arbiter in front of the single shared memory port.
- Generalises the fixed VGA-plus-core sharing to NUM_PORTS requesters: display, core, and future DMA or UART.
- Grants one request per cycle and registers the command onto the memory port.
- Tracks read ownership through a RD_LAT-deep tag pipeline and routes each read response to its issuer.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_W, 15, word address width.
- DATA_W, 16, data word width.
- RD_LAT, 1, memory read latency in cycles, measured from the registered command to valid mem_rdata (1..4).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_PORTS  per-port request; held with payload until granted.
- we  in  NUM_PORTS  per-port write enable (1 = write, 0 = read).
- addr  in  NUM_PORTS*ADDR_W  flattened addresses; port i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  flattened write data, same packing.
- gnt  out  NUM_PORTS  one-hot grant, combinational, same cycle as the winning req.
- rvalid  out  NUM_PORTS  one-hot read-response strobe, one cycle wide.
- rdata  out  DATA_W  read data, broadcast to all ports; qualified by rvalid.
- mem_en  out  1  registered memory command strobe.
- mem_we  out  1  registered memory write enable.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
Reset values:
- gnt = 0, rvalid = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0.
- Round-robin pointer = 0; tag pipeline cleared.

Arbitration:
- Search starts at the pointer and wraps modulo NUM_PORTS; the first port with req=1 wins.
- gnt[winner]=1 in the same cycle. At most one gnt bit is ever set. gnt=0 when no req.
- On grant to port k, the pointer becomes (k+1) mod NUM_PORTS. With no grant, the pointer holds.
- Handshake: a request completes in the cycle where req[i] & gnt[i]. The requester may drop req or present a new request in the next cycle.
- Back-to-back grants to the same port are allowed when it is the only requester.

Command stage:
- On the edge ending a grant cycle, mem_en=1 and mem_we/mem_addr/mem_wdata are loaded from the winner.
- In a cycle with no grant, mem_en=0 on the next edge and the other mem_* outputs hold their previous values.
- Throughput: one command per cycle.

Response stage:
- A shift register RD_LAT entries deep carries {valid, port id}.
- Entry 0 is loaded at the command edge with valid = mem_en & ~mem_we.
- The entry emerging RD_LAT cycles after the command drives rvalid[id]=1. rdata is registered from mem_rdata in the same cycle.
- Read latency from grant cycle T: rvalid is asserted in cycle T+1+RD_LAT.
- Writes produce no rvalid.
- Responses return strictly in issue order; no reordering.

Boundaries:
- All ports requesting every cycle: each port is granted exactly once per NUM_PORTS cycles.
- A req that drops before being granted is discarded; no state is retained.
- Reset asserted mid-operation: in-flight reads are discarded, no rvalid fires after reset, and the pointer returns to 0.
- addr/wdata of non-winning ports are ignored.

Optional Feature:
- Macro: MEM_ARB_PORT0_PRIORITY_EN.
- When defined: port 0 (display refill) has absolute priority. If req[0]=1 it wins regardless of the pointer, and the pointer is not updated. The remaining ports round-robin among themselves using the same pointer rule over ports 1..NUM_PORTS-1.
- When undefined: pure round-robin over all ports as described above.
- Starvation of ports 1..N-1 under continuous req[0] is accepted when the macro is defined.

Test Plan:
- Reset then idle, NUM_PORTS=2, RD_LAT=1 -> gnt=0 and mem_en=0 for 10 cycles; rvalid never asserted.
- Port 1 single read addr=0x0123, memory model returns 0xBEEF -> gnt[1] in T; mem_en=1, mem_addr=0x0123 at T+1; rvalid[1]=1, rdata=0xBEEF at T+2; rvalid[0]=0 throughout.
- Ports 0 and 1 request continuously for 8 cycles (reads), macro off -> grants alternate 0,1,0,1…; 4 rvalid per port, each matching its issued address.
- Write then read: port 0 writes 0x5A5A to 0x0010, then port 1 reads 0x0010 -> mem_we=1 for the write, no rvalid for the write; port 1 receives 0x5A5A.
- Reset asserted the cycle after a read grant with RD_LAT=3 -> no rvalid after reset release; pointer=0, so with both requesting, port 0 is granted first.
- Macro on, NUM_PORTS=3, all requesting for 6 cycles -> port 0 granted all 6 cycles; ports 1 and 2 ungranted; drop req[0] -> grants alternate 1,2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// N-port round-robin arbiter for the shared memory port, with in-order read-response routing.
// Build option: define MEM_ARB_PORT0_PRIORITY_EN to give port 0 absolute priority.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);
  localparam int IDW = $clog2(NUM_PORTS);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_PORTS - 1);
  localparam logic [IDW:0]   NP_W    = (IDW + 1)'(NUM_PORTS);

  logic [IDW-1:0]       ptr_q, ptr_d;
  logic                 win_vld;
  logic [IDW-1:0]       win_id;
  logic                 hold_ptr;
  logic [IDW:0]         scan_sum;
  logic [IDW-1:0]       scan_id;

  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic [RD_LAT-1:0]    tag_vld_q, tag_vld_d;
  logic [IDW-1:0]       tag_id_q [RD_LAT];
  logic [IDW-1:0]       tag_id_d [RD_LAT];

  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    hold_ptr = 1'b0;
    scan_sum = '0;
    scan_id  = '0;
    // Scan from the far offset down so the requester nearest the pointer is written last and wins.
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      scan_sum = {1'b0, ptr_q} + (IDW + 1)'(off);
      if (scan_sum >= NP_W) scan_sum = scan_sum - NP_W;
      scan_id = scan_sum[IDW-1:0];
      if (req[scan_id]) begin
        win_vld = 1'b1;
        win_id  = scan_id;
      end
    end
`ifdef MEM_ARB_PORT0_PRIORITY_EN
    if (req[0]) begin
      win_vld  = 1'b1;
      win_id   = '0;
      hold_ptr = 1'b1;
    end
`endif
    if (reset) win_vld = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (win_vld) gnt[win_id] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    mem_en_d    = win_vld;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (win_vld) begin
      if (!hold_ptr) ptr_d = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
      mem_we_d    = we[win_id];
      mem_addr_d  = addr[int'(win_id)*ADDR_W +: ADDR_W];
      mem_wdata_d = wdata[int'(win_id)*DATA_W +: DATA_W];
    end
  end

  // Read ownership travels alongside the memory latency; writes enter as invalid slots.
  always_comb begin
    tag_vld_d[0] = win_vld & ~we[win_id];
    tag_id_d[0]  = win_id;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (tag_vld_q[RD_LAT-1]) begin
      rvalid_d[tag_id_q[RD_LAT-1]] = 1'b1;
      rdata_d                      = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_id_q[i] <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_vld_q   <= tag_vld_d;
      for (int i = 0; i < RD_LAT; i++) tag_id_q[i] <= tag_id_d[i];
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (2 ports/RD_LAT=1 and 3 ports/RD_LAT=3) driven
// from shared stimulus and compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW  = 15;
  localparam int DW  = 16;
  localparam int NPA = 2;
  localparam int NPB = 3;
  localparam int RLA = 1;
  localparam int RLB = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [2:0]    req_v, we_v;
  logic [AW-1:0] addr_v  [3];
  logic [DW-1:0] wdata_v [3];

  logic [NPA-1:0]    req_a, we_a, gnt_a, rvalid_a;
  logic [NPA*AW-1:0] addr_a;
  logic [NPA*DW-1:0] wdata_a;
  logic [DW-1:0]     rdata_a, mem_wdata_a, mem_rdata_a;
  logic              mem_en_a, mem_we_a;
  logic [AW-1:0]     mem_addr_a;

  logic [NPB-1:0]    req_b, we_b, gnt_b, rvalid_b;
  logic [NPB*AW-1:0] addr_b;
  logic [NPB*DW-1:0] wdata_b;
  logic [DW-1:0]     rdata_b, mem_wdata_b, mem_rdata_b;
  logic              mem_en_b, mem_we_b;
  logic [AW-1:0]     mem_addr_b;

  assign req_a   = req_v[1:0];
  assign we_a    = we_v[1:0];
  assign addr_a  = {addr_v[1], addr_v[0]};
  assign wdata_a = {wdata_v[1], wdata_v[0]};
  assign req_b   = req_v;
  assign we_b    = we_v;
  assign addr_b  = {addr_v[2], addr_v[1], addr_v[0]};
  assign wdata_b = {wdata_v[2], wdata_v[1], wdata_v[0]};

  // Memory seen by each DUT; written from the stimulus process when a write command is on the bus.
  logic [DW-1:0] dmem    [2][1<<AW];
  logic [DW-1:0] ref_mem [2][1<<AW];
  logic [DW-1:0] line_b0, line_b1;

  assign mem_rdata_a = dmem[0][mem_addr_a];
  always @(posedge clk) begin
    line_b0 <= dmem[1][mem_addr_b];
    line_b1 <= line_b0;
  end
  assign mem_rdata_b = line_b1;

  mem_port_arbiter #(.NUM_PORTS(NPA), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RLA)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .mem_en(mem_en_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a));

  mem_port_arbiter #(.NUM_PORTS(NPB), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RLB)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b));

  // Reference model: grant rule, held command register, and an ordered list of due responses.
  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         rq_a[$];
  resp_t         rq_b[$];
  int            m_ptr   [2];
  int            m_win   [2];
  logic          m_en    [2];
  logic          m_we    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];

  int g_cnt  [3];
  int rv_cnt [3];

  function automatic int nports(input int inst);
    return (inst == 0) ? NPA : NPB;
  endfunction

  function automatic int rdlat(input int inst);
    return (inst == 0) ? RLA : RLB;
  endfunction

  function automatic int pick(input int inst, input logic [2:0] r);
    int n;
    int p;
    n = nports(inst);
`ifdef MEM_ARB_PORT0_PRIORITY_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < n; k++) begin
      p = (m_ptr[inst] + k) % n;
      if (r[p[1:0]]) return p;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_inst(input int inst, input logic [2:0] o_gnt, input logic [2:0] o_rv,
                            input logic o_en, input logic o_we, input logic [AW-1:0] o_addr,
                            input logic [DW-1:0] o_wd, input logic [DW-1:0] o_rd);
    string      nm;
    logic [2:0] e_gnt;
    logic [2:0] e_rv;
    resp_t      h;
    bit         have;
    nm   = (inst == 0) ? "A" : "B";
    have = 1'b0;
    m_win[inst] = pick(inst, (inst == 0) ? {1'b0, req_v[1:0]} : req_v);
    e_gnt = (m_win[inst] >= 0) ? 3'(1 << m_win[inst]) : 3'b000;
    chk({nm, ".gnt"},       32'(o_gnt),  32'(e_gnt));
    chk({nm, ".mem_en"},    32'(o_en),   32'(m_en[inst]));
    chk({nm, ".mem_we"},    32'(o_we),   32'(m_we[inst]));
    chk({nm, ".mem_addr"},  32'(o_addr), 32'(m_addr[inst]));
    chk({nm, ".mem_wdata"}, 32'(o_wd),   32'(m_wdata[inst]));
    if (inst == 0) begin
      if (rq_a.size() > 0 && rq_a[0].due == cyc) begin h = rq_a.pop_front(); have = 1'b1; end
    end else begin
      if (rq_b.size() > 0 && rq_b[0].due == cyc) begin h = rq_b.pop_front(); have = 1'b1; end
    end
    e_rv = have ? 3'(1 << h.port) : 3'b000;
    chk({nm, ".rvalid"}, 32'(o_rv), 32'(e_rv));
    if (have) chk({nm, ".rdata"}, 32'(o_rd), 32'(h.data));
  endtask

  task automatic cycle_begin();
    @(negedge clk);
    check_inst(0, {1'b0, gnt_a}, {1'b0, rvalid_a}, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a, rdata_a);
    check_inst(1, gnt_b, rvalid_b, mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b, rdata_b);
  endtask

  task automatic cycle_end();
    int    w;
    resp_t r;
    for (int inst = 0; inst < 2; inst++) begin
      w = m_win[inst];
      if (w >= 0) begin
        m_en[inst]    = 1'b1;
        m_we[inst]    = we_v[w[1:0]];
        m_addr[inst]  = addr_v[w];
        m_wdata[inst] = wdata_v[w];
        if (we_v[w[1:0]]) begin
          ref_mem[inst][addr_v[w]] = wdata_v[w];
        end else begin
          r.due  = cyc + 1 + rdlat(inst);
          r.port = w;
          r.data = ref_mem[inst][addr_v[w]];
          if (inst == 0) rq_a.push_back(r);
          else           rq_b.push_back(r);
        end
`ifdef MEM_ARB_PORT0_PRIORITY_EN
        if (w != 0) m_ptr[inst] = (w + 1) % nports(inst);
`else
        m_ptr[inst] = (w + 1) % nports(inst);
`endif
      end else begin
        m_en[inst] = 1'b0;
      end
    end
    if (mem_en_a && mem_we_a) dmem[0][mem_addr_a] = mem_wdata_a;
    if (mem_en_b && mem_we_b) dmem[1][mem_addr_b] = mem_wdata_b;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    req_v = '0;
    we_v  = '0;
    repeat (n) begin
      cycle_begin();
      cycle_end();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    req_v = '0;
    we_v  = '0;
    repeat (n) begin
      @(negedge clk);
      chk("rst.A.gnt",       32'(gnt_a),       32'h0);
      chk("rst.A.rvalid",    32'(rvalid_a),    32'h0);
      chk("rst.A.rdata",     32'(rdata_a),     32'h0);
      chk("rst.A.mem_en",    32'(mem_en_a),    32'h0);
      chk("rst.A.mem_we",    32'(mem_we_a),    32'h0);
      chk("rst.A.mem_addr",  32'(mem_addr_a),  32'h0);
      chk("rst.A.mem_wdata", 32'(mem_wdata_a), 32'h0);
      chk("rst.B.gnt",       32'(gnt_b),       32'h0);
      chk("rst.B.rvalid",    32'(rvalid_b),    32'h0);
      chk("rst.B.rdata",     32'(rdata_b),     32'h0);
      chk("rst.B.mem_en",    32'(mem_en_b),    32'h0);
      chk("rst.B.mem_we",    32'(mem_we_b),    32'h0);
      chk("rst.B.mem_addr",  32'(mem_addr_b),  32'h0);
      chk("rst.B.mem_wdata", 32'(mem_wdata_b), 32'h0);
      @(posedge clk);
      cyc++;
      #1;
    end
    for (int inst = 0; inst < 2; inst++) begin
      m_ptr[inst]   = 0;
      m_win[inst]   = -1;
      m_en[inst]    = 1'b0;
      m_we[inst]    = 1'b0;
      m_addr[inst]  = '0;
      m_wdata[inst] = '0;
    end
    rq_a.delete();
    rq_b.delete();
    reset = 1'b0;
  endtask

  task automatic clear_counts();
    for (int p = 0; p < 3; p++) begin
      g_cnt[p]  = 0;
      rv_cnt[p] = 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    req_v = '0;
    we_v  = '0;
    for (int p = 0; p < 3; p++) begin
      addr_v[p]  = '0;
      wdata_v[p] = '0;
    end
    for (int a = 0; a < (1 << AW); a++) begin
      dmem[0][a]    = 16'(a * 7) ^ 16'h3C5A;
      dmem[1][a]    = 16'(a * 7) ^ 16'h3C5A;
      ref_mem[0][a] = 16'(a * 7) ^ 16'h3C5A;
      ref_mem[1][a] = 16'(a * 7) ^ 16'h3C5A;
    end
    dmem[0][15'h0123]    = 16'hBEEF;
    dmem[1][15'h0123]    = 16'hBEEF;
    ref_mem[0][15'h0123] = 16'hBEEF;
    ref_mem[1][15'h0123] = 16'hBEEF;

    do_reset(3);
    idle(10);

    // Port 1 single read of 0x0123
    req_v = 3'b010; we_v = 3'b000; addr_v[1] = 15'h0123;
    cycle_begin();
    chk("A.rd1.gnt", 32'(gnt_a), 32'h2);
    cycle_end();
    req_v = '0;
    cycle_begin();
    chk("A.rd1.mem_en",   32'(mem_en_a),   32'h1);
    chk("A.rd1.mem_addr", 32'(mem_addr_a), 32'h0123);
    cycle_end();
    cycle_begin();
    chk("A.rd1.rvalid", 32'(rvalid_a), 32'h2);
    chk("A.rd1.rdata",  32'(rdata_a),  32'hBEEF);
    cycle_end();
    idle(4);

    // Ports 0 and 1 reading continuously for 8 cycles
    clear_counts();
    req_v = 3'b011; we_v = 3'b000;
    for (int i = 0; i < 8; i++) begin
      addr_v[0] = 15'(16'h0040 + i);
      addr_v[1] = 15'(16'h0080 + i);
      cycle_begin();
      for (int p = 0; p < 2; p++) begin
        if (gnt_a[p])    g_cnt[p]++;
        if (rvalid_a[p]) rv_cnt[p]++;
      end
      cycle_end();
    end
    req_v = '0;
    repeat (4) begin
      cycle_begin();
      for (int p = 0; p < 2; p++) if (rvalid_a[p]) rv_cnt[p]++;
      cycle_end();
    end
`ifdef MEM_ARB_PORT0_PRIORITY_EN
    chk("A.cont.gnt0", 32'(g_cnt[0]),  32'd8);
    chk("A.cont.gnt1", 32'(g_cnt[1]),  32'd0);
    chk("A.cont.rv0",  32'(rv_cnt[0]), 32'd8);
    chk("A.cont.rv1",  32'(rv_cnt[1]), 32'd0);
`else
    chk("A.cont.gnt0", 32'(g_cnt[0]),  32'd4);
    chk("A.cont.gnt1", 32'(g_cnt[1]),  32'd4);
    chk("A.cont.rv0",  32'(rv_cnt[0]), 32'd4);
    chk("A.cont.rv1",  32'(rv_cnt[1]), 32'd4);
`endif

    // Port 0 writes 0x5A5A to 0x0010, then port 1 reads it back
    req_v = 3'b001; we_v = 3'b001; addr_v[0] = 15'h0010; wdata_v[0] = 16'h5A5A;
    cycle_begin();
    cycle_end();
    req_v = 3'b010; we_v = 3'b000; addr_v[1] = 15'h0010;
    cycle_begin();
    chk("A.wr.mem_we",    32'(mem_we_a),    32'h1);
    chk("A.wr.mem_wdata", 32'(mem_wdata_a), 32'h5A5A);
    cycle_end();
    req_v = '0;
    cycle_begin();
    chk("A.wr.no_rvalid", 32'(rvalid_a), 32'h0);
    chk("A.rd.mem_we",    32'(mem_we_a), 32'h0);
    cycle_end();
    cycle_begin();
    chk("A.rbw.rvalid", 32'(rvalid_a), 32'h2);
    chk("A.rbw.rdata",  32'(rdata_a),  32'h5A5A);
    cycle_end();
    idle(5);

    // Reset right after a read grant: nothing may come back afterwards
    req_v = 3'b111; we_v = 3'b000;
    addr_v[0] = 15'h0200; addr_v[1] = 15'h0201; addr_v[2] = 15'h0202;
    cycle_begin();
    cycle_end();
    do_reset(2);
    idle(6);
    req_v = 3'b011; we_v = 3'b000;
    cycle_begin();
    chk("A.post_rst.gnt", 32'(gnt_a), 32'h1);
    chk("B.post_rst.gnt", 32'(gnt_b), 32'h1);
    cycle_end();
    idle(5);

    // All three ports requesting for 6 cycles, then port 0 drops
    clear_counts();
    req_v = 3'b111; we_v = 3'b000;
    for (int i = 0; i < 6; i++) begin
      cycle_begin();
      for (int p = 0; p < 3; p++) if (gnt_b[p]) g_cnt[p]++;
      cycle_end();
    end
`ifdef MEM_ARB_PORT0_PRIORITY_EN
    chk("B.all.gnt0", 32'(g_cnt[0]), 32'd6);
    chk("B.all.gnt1", 32'(g_cnt[1]), 32'd0);
    chk("B.all.gnt2", 32'(g_cnt[2]), 32'd0);
`else
    chk("B.all.gnt0", 32'(g_cnt[0]), 32'd2);
    chk("B.all.gnt1", 32'(g_cnt[1]), 32'd2);
    chk("B.all.gnt2", 32'(g_cnt[2]), 32'd2);
`endif
    req_v = 3'b110;
    for (int i = 0; i < 4; i++) begin
      cycle_begin();
      chk("B.alt12.gnt", 32'(gnt_b), (i % 2 == 0) ? 32'h2 : 32'h4);
      cycle_end();
    end
    idle(6);

    // Random traffic over a small address window so reads hit earlier writes
    for (int i = 0; i < 400; i++) begin
      req_v = 3'($urandom_range(0, 7));
      we_v  = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) begin
        addr_v[p]  = 15'($urandom_range(0, 15));
        wdata_v[p] = 16'($urandom);
      end
      cycle_begin();
      cycle_end();
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
